ldw_mem: RTL

- Memory stage of the ldw 5-stage pipeline. It consumes the EXE stage results (ALU result, store data, destination register, control bits).
- Holds the EXE/MEM and MEM/WB pipeline latches.
- Drives a req/ack data-memory bus, stalling the pipeline until each load or store is acknowledged.
- Provides the MEM-stage and WB-stage values to the forwarding logic.

---
 rtl/ldw_mem.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ldw_mem.sv
// ldw_mem: memory stage of the ldw 5-stage pipeline.
// It holds the EXE/MEM and MEM/WB pipeline latches. It drives a req/ack
// data-memory bus and stalls the pipeline until each load or store is
// acknowledged. It also exposes the MEM-stage and WB-stage values for
// forwarding.
//
// Optional feature macro: LDW_MEM_ALIGN_CHECK_EN. When it is defined, a load
// or store whose word address is misaligned is not issued to memory. The
// access is aborted with merr set and wmo = TIMEOUT_DATA.
//
// Ports:
//   clk, clrn                          clock (rising edge), async active-low reset
//   ewreg, em2reg, ewmem, ern,
//   ealu, eb                           EXE-stage results and control
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack      data-memory req/ack bus
//   mstall                             freeze PC, IF/ID, ID/EXE and EXE/MEM
//   mwreg, mm2reg, mrn, malu           MEM-stage values for forwarding
//   wwreg, wm2reg, wrn, walu, wmo      WB-stage values
//   merr                               sticky access error (timeout / misalignment)
module ldw_mem #(
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mstall,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic [31:0] walu,
    output logic [31:0] wmo,
    output logic        merr
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic             mwmem;
    logic [31:0]      mb;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic memop;
    logic misalign;
    logic live;
    logic complete;
    logic timeout_hit;
    logic timeout;

    // An access is live while a memop sits in MEM and has not been aborted.
    always_comb begin
        memop = mm2reg | mwmem;
`ifdef LDW_MEM_ALIGN_CHECK_EN
        misalign = memop & (malu[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        live     = memop & (state != DONE) & ~misalign;
        complete = live & mem_ack;
    end

    // Bus and stall outputs are combinational so that a same-cycle ack costs no stall.
    always_comb begin
        mem_req   = live;
        mem_we    = mwmem;
        mem_addr  = malu;
        mem_wdata = mb;
        mstall    = live & ~mem_ack;
    end

    // The IDLE cycle counts as the first stalled cycle. The abort therefore
    // fires in the WAIT cycle in which cnt+1 reaches ACK_TIMEOUT-1. That gives
    // ACK_TIMEOUT stalled cycles in total.
    always_comb begin
        timeout_hit = (ACK_TIMEOUT != 0) &&
                      ((32'(cnt) + 32'd1) >= (32'(ACK_TIMEOUT) - 32'd1));
        timeout     = (state == WAIT) & ~mem_ack & timeout_hit;
    end

    // Access FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Access FSM next-state logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (live & ~mem_ack) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // EXE/MEM latch: frozen while the current access is stalled.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mrn    <= 5'd0;
            malu   <= 32'd0;
            mb     <= 32'd0;
        end else if (!mstall) begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrn    <= ern;
            malu   <= ealu;
            mb     <= eb;
        end
    end

    // MEM/WB latch: a bubble (wwreg = 0) enters while stalled.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wrn    <= 5'd0;
            walu   <= 32'd0;
        end else if (mstall) begin
            wwreg  <= 1'b0;
        end else begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            wrn    <= mrn;
            walu   <= malu;
        end
    end

    // Load data and the sticky error flag. Aborted accesses return TIMEOUT_DATA.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wmo  <= 32'd0;
            merr <= 1'b0;
        end else begin
            if (complete & mm2reg) begin
                wmo <= mem_rdata;
            end else if (timeout | misalign) begin
                wmo <= TIMEOUT_DATA;
            end
            if (timeout | misalign) begin
                merr <= 1'b1;
            end
        end
    end

endmodule
